// File: rtl/image_pkg.sv
// ----------------------------------------------------------------------------
// image_pkg
// Shared types and helpers for the image pyramid datapath.
//   PIX_W     : default pixel width
//   pix_t     : one pixel
//   pairsum_t : sum of two horizontally adjacent pixels (one extra bit)
//   blksum_t  : sum of a full 2x2 block (two extra bits)
//   avg4()    : 2x2 block sum -> block average
// Build option: DOWNSCALE_ROUND_EN selects round-half-up averaging in avg4();
// left undefined, avg4() truncates.
// ----------------------------------------------------------------------------
package image_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [PIX_W:0]   pairsum_t;
    typedef logic [PIX_W+1:0] blksum_t;

    // Four pixels sum to at most 4*(2^PIX_W - 1), so adding 2 still fits.
    function automatic pix_t avg4(input blksum_t sum);
        blksum_t biased;
`ifdef DOWNSCALE_ROUND_EN
        biased = sum + blksum_t'(2);
`else
        biased = sum;
`endif
        return biased[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/image_line_ram.sv
// ----------------------------------------------------------------------------
// image_line_ram
// Simple dual-port line buffer with a one-cycle registered read. The read
// register keeps its value until the next read is issued.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable
//   raddr_i : read address
//   rdata_o : registered read data (valid the cycle after re_i)
// ----------------------------------------------------------------------------
module image_line_ram #(
    parameter int Depth = 640,
    parameter int Width = 9,
    parameter int Aw    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];

    // NOTE: the array has no reset so it maps onto block RAM; nothing reads
    // an entry before the even row of the same frame has written it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/image_downscale_2x.sv
// ----------------------------------------------------------------------------
// image_downscale_2x
// Streaming 2x2 box-filter decimator. Even rows store horizontal pair sums in
// a one-line buffer; odd rows add their own pair to the buffered pair and emit
// the block average, giving a half-width, half-height stream.
//   clk          : clock
//   rst          : synchronous active-high reset
//   i_image_vs   : frame sync, high between frames
//   i_image_hs   : high for each active input line
//   i_image_en   : pixel qualifier (ignored while i_image_hs is low)
//   i_image_data : input pixel
//   o_image_vs   : i_image_vs delayed one cycle
//   o_image_hs   : i_image_hs on odd input rows, delayed one cycle
//   o_image_en   : one pulse per completed 2x2 block
//   o_image_data : block average
// Build option: DOWNSCALE_ROUND_EN (round half up instead of truncating).
// Max_Width must be even and at least 4.
// ----------------------------------------------------------------------------
module image_downscale_2x
    import image_pkg::*;
#(
    parameter int Pra_Width = PIX_W,
    parameter int Max_Width = 1280
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_image_vs,
    input  logic                 i_image_hs,
    input  logic                 i_image_en,
    input  logic [Pra_Width-1:0] i_image_data,
    output logic                 o_image_vs,
    output logic                 o_image_hs,
    output logic                 o_image_en,
    output logic [Pra_Width-1:0] o_image_data
);

    localparam int CNT_W = $clog2(Max_Width + 1);
    localparam int AW    = $clog2(Max_Width / 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(Max_Width);

    logic [CNT_W-1:0]     col_cnt_q, col_cnt_d;
    logic                 row_par_q, row_par_d;
    logic                 hs_prev_q, hs_prev_d;
    logic [Pra_Width-1:0] pix_hold_q, pix_hold_d;
    logic                 vs_q, vs_d;
    logic                 hs_q, hs_d;
    logic                 en_q, en_d;
    logic [Pra_Width-1:0] data_q, data_d;

    logic                 hs_fall;
    logic                 accept;
    logic                 odd_col;
    logic [AW-1:0]        pair_idx;
    logic                 ram_we;
    logic                 ram_re;
    logic [Pra_Width:0]   ram_wdata;
    logic [Pra_Width:0]   ram_rdata;
    logic [Pra_Width+1:0] blk_sum;

    assign hs_fall = hs_prev_q & ~i_image_hs;
    // Columns at or beyond Max_Width are dropped; the counter stops there.
    assign accept  = i_image_hs & i_image_en & ~i_image_vs & (col_cnt_q < MAX_CNT);
    assign odd_col = col_cnt_q[0];
    // accept guarantees col_cnt_q < Max_Width, so the pair index fits AW bits.
    assign pair_idx = col_cnt_q[AW:1];

    assign ram_wdata = {1'b0, pix_hold_q} + {1'b0, i_image_data};
    assign blk_sum   = {1'b0, ram_rdata} + {2'b00, pix_hold_q} + {2'b00, i_image_data};
    assign ram_we    = accept & ~row_par_q & odd_col;
    // The read issued on the even column is consumed on the next odd column.
    assign ram_re    = accept & row_par_q & ~odd_col;

    image_line_ram #(
        .Depth (Max_Width / 2),
        .Width (Pra_Width + 1),
        .Aw    (AW)
    ) u_line_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (pair_idx),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (pair_idx),
        .rdata_o (ram_rdata)
    );

    // NOTE: every next-state signal takes a default first so this block
    // stays purely combinational.
    always_comb begin
        col_cnt_d  = col_cnt_q;
        row_par_d  = row_par_q;
        hs_prev_d  = i_image_hs;
        pix_hold_d = pix_hold_q;
        vs_d       = i_image_vs;
        hs_d       = i_image_hs & row_par_q & ~i_image_vs;
        en_d       = 1'b0;
        data_d     = data_q;

        if (i_image_vs) begin
            // Frame sync aborts any partial line; clearing hs_prev also stops
            // a late hs fall from toggling the parity of the next frame.
            col_cnt_d = '0;
            row_par_d = 1'b0;
            hs_prev_d = 1'b0;
        end else begin
            if (hs_fall) begin
                col_cnt_d = '0;
                row_par_d = ~row_par_q;
            end else if (accept) begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            if (accept && !odd_col) begin
                pix_hold_d = i_image_data;
            end

            if (accept && row_par_q && odd_col) begin
                en_d   = 1'b1;
                data_d = avg4(blksum_t'(blk_sum));
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q  <= '0;
            row_par_q  <= 1'b0;
            hs_prev_q  <= 1'b0;
            pix_hold_q <= '0;
            vs_q       <= 1'b0;
            hs_q       <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            row_par_q  <= row_par_d;
            hs_prev_q  <= hs_prev_d;
            pix_hold_q <= pix_hold_d;
            vs_q       <= vs_d;
            hs_q       <= hs_d;
            en_q       <= en_d;
            data_q     <= data_d;
        end
    end

    assign o_image_vs   = vs_q;
    assign o_image_hs   = hs_q;
    assign o_image_en   = en_q;
    assign o_image_data = data_q;

endmodule

// File: tb/tb_image_downscale_2x.sv
// ----------------------------------------------------------------------------
// tb_image_downscale_2x
// Drives whole frames from a 2D image array; the reference computes each
// output directly as the average of the 2x2 block in that array, together
// with the cycle on which it must appear. A negedge monitor compares the DUT
// output stream and the delayed sync signals against those expectations.
// ----------------------------------------------------------------------------
module tb_image_downscale_2x;

    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_image_vs = 1'b0;
    logic       i_image_hs = 1'b0;
    logic       i_image_en = 1'b0;
    logic [7:0] i_image_data = 8'd0;
    logic       o_image_vs;
    logic       o_image_hs;
    logic       o_image_en;
    logic [7:0] o_image_data;

    image_downscale_2x #(
        .Pra_Width (8),
        .Max_Width (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_image_vs   (i_image_vs),
        .i_image_hs   (i_image_hs),
        .i_image_en   (i_image_en),
        .i_image_data (i_image_data),
        .o_image_vs   (o_image_vs),
        .o_image_hs   (o_image_hs),
        .o_image_en   (o_image_en),
        .o_image_data (o_image_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] img [0:15][0:15];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       mon_en = 1'b0;
    logic       row_odd = 1'b0;
    logic       exp_vs_nx = 1'b0;
    logic       exp_hs_nx = 1'b0;
    logic       exp_vs = 1'b0;
    logic       exp_hs = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: average of the 2x2 block whose bottom-right pixel is (r,c).
    function automatic int block_avg(input int r, input int c);
        int sum;
        sum = int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(img[r][c]);
`ifdef DOWNSCALE_ROUND_EN
        return (sum + 2) / 4;
`else
        return sum / 4;
`endif
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        exp_vs <= exp_vs_nx;
        exp_hs <= exp_hs_nx;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("o_vs", o_image_vs, exp_vs);
            check("o_hs", o_image_hs, exp_hs);
            if (o_image_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", o_image_data, e.data);
                    check("latency_cyc", cyc, e.cyc);
                end
            end
        end
    end

    // Apply one cycle of input, then wait until just after the sampling edge.
    task automatic step(input logic vs, input logic hs, input logic en, input logic [7:0] d);
        i_image_vs   = vs;
        i_image_hs   = hs;
        i_image_en   = en;
        i_image_data = d;
        exp_vs_nx    = rst ? 1'b0 : vs;
        exp_hs_nx    = rst ? 1'b0 : (hs & row_odd & ~vs);
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int r, input int npix, input bit gaps, input bit abort);
        row_odd = r[0];
        for (int c = 0; c < npix; c++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            end
            if (r[0] && c[0] && c < MAXW) begin
                exp_q.push_back('{block_avg(r, c), cyc + 1});
            end
            step(1'b0, 1'b1, 1'b1, img[r][c]);
        end
        if (!abort) begin
            // en while hs is low must be ignored
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps,
                              input int abort_row, input int abort_pix);
        row_odd = 1'b0;
        repeat ($urandom_range(1, 2)) step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int r = 0; r < h; r++) begin
            if (r == abort_row) begin
                send_line(r, abort_pix, gaps, 1'b1);
                return;
            end
            send_line(r, w, gaps, 1'b0);
        end
    endtask

    task automatic finish_frame(input string tag);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("rst_vs", o_image_vs, 0);
        check("rst_hs", o_image_hs, 0);
        check("rst_en", o_image_en, 0);
        check("rst_data", o_image_data, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        mon_en = 1'b1;

        // 4x4 flat frame, continuous en
        fill_const(8'd100);
        send_frame(4, 4, 1'b0, -1, 0);
        finish_frame("flat_left");

        // Rounding case: block 1,1,2,2
        img[0][0] = 8'd1; img[0][1] = 8'd1;
        img[1][0] = 8'd2; img[1][1] = 8'd2;
        send_frame(2, 2, 1'b0, -1, 0);
        finish_frame("round_left");

        // Saturated block
        fill_const(8'd255);
        send_frame(2, 2, 1'b0, -1, 0);
        finish_frame("max_left");

        // Odd width and odd height
        fill_rand();
        send_frame(5, 3, 1'b0, -1, 0);
        finish_frame("odd_left");

        // Lines longer than Max_Width, gapped
        fill_rand();
        send_frame(10, 4, 1'b1, -1, 0);
        finish_frame("wide_left");

        // vs mid odd row, then a clean ramp frame
        fill_rand();
        send_frame(4, 4, 1'b0, 1, 3);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = 8'(r * 40 + c * 13);
        send_frame(4, 4, 1'b0, -1, 0);
        finish_frame("abort_left");

        // Random frames
        for (int k = 0; k < 8; k++) begin
            fill_rand();
            send_frame($urandom_range(2, 12), $urandom_range(2, 6), 1'($urandom_range(0, 1)), -1, 0);
            finish_frame("rand_left");
        end

        // Reset mid odd row with gapped en
        fill_rand();
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        send_line(0, 6, 1'b1, 1'b0);
        send_line(1, 3, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h5a);
        rst = 1'b0;
        check("midrst_vs", o_image_vs, 0);
        check("midrst_hs", o_image_hs, 0);
        check("midrst_en", o_image_en, 0);
        check("midrst_data", o_image_data, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("midrst_left", exp_q.size(), 0);
        exp_q.delete();
        fill_rand();
        send_frame(6, 4, 1'b1, -1, 0);
        finish_frame("post_rst_left");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/image_downscale_2x.md
# image_downscale_2x

Streaming 2x2 box-filter decimator for the ORB image pyramid. It consumes the pixel stream in image_vs/hs/en/data format and emits a half-width, half-height stream in the same format. It sits directly upstream of the FAST detector for each pyramid level above level 0. One even-row line of horizontal pair sums is buffered, so no frame storage is needed.

## Interface
- Pra_Width, 8: pixel data width.
- Max_Width, 1280: maximum input line width in pixels (even); line buffer depth is Max_Width/2.
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- i_image_vs  input  1  frame sync; high pulse (>=1 cycle) between frames, low during active frame.
- i_image_hs  input  1  high for the whole of each active input line.
- i_image_en  input  1  pixel qualifier; only meaningful while i_image_hs is high.
- i_image_data  input  Pra_Width  pixel value, valid when i_image_en is high.
- o_image_vs  output  1  i_image_vs delayed 1 cycle.
- o_image_hs  output  1  high during odd input rows only, delayed 1 cycle.
- o_image_en  output  1  one pulse per completed 2x2 block.
- o_image_data  output  Pra_Width  block average.

## Operation
- Counters:
  - col_cnt counts en pulses within a line and clears on the hs falling edge.
  - row_par toggles on each hs falling edge.
  - Both clear while i_image_vs is high, and on rst.
- Column parity is col_cnt[0]; pair index is col_cnt>>1.
- Even row (row_par=0):
  - Even column: register the pixel in pix_hold.
  - Odd column: write pix_hold+pixel (Pra_Width+1 bits) to the line buffer at the pair index.
- Odd row (row_par=1):
  - Even column: register the pixel and issue a line-buffer read at the pair index.
  - Odd column: sum = buffered pair + pix_hold + pixel (Pra_Width+2 bits, no overflow). Register the result as o_image_data = sum>>2 (rounding per Configuration) and pulse o_image_en.
- Odd-length lines: the trailing unpaired pixel is dropped. An odd final row of a frame produces no output.
- Pixels with col_cnt >= Max_Width are ignored: no write, no read, no output. The counter saturates at Max_Width.
- i_image_en while i_image_hs is low is ignored.
- Line buffer contents are not cleared. A stale buffer is never read, because an odd row always follows a written even row within a frame.

## Timing
- Reset values: o_image_vs=0, o_image_hs=0, o_image_en=0, o_image_data=0. Internal counters, row_par and pix_hold are 0.
- Line buffer read latency is 1 cycle. A read issued on the even-column en is consumed on the following odd-column en, which occurs one or more cycles later. The read data register holds its value until the next read.
- Output latency is 1 cycle: o_image_en rises on the cycle after the odd-row, odd-column input en. vs and hs carry the same 1-cycle delay, so alignment is preserved.
- Back-to-back input en (one pixel per cycle) gives an output en every second cycle on odd rows. Gapped en is fully supported.
- i_image_vs rising mid-line aborts the line: counters clear and any pending pair is discarded.
- rst mid-frame: outputs go to 0 on the next edge and the block resynchronises on the next vs.

## Configuration
- DOWNSCALE_ROUND_EN:
  - Defined: o_image_data = (sum+2)>>2, round half up.
  - Undefined: o_image_data = sum>>2, truncate.
- The +2 cannot overflow Pra_Width+2 bits.

## Structure
- Package image_pkg holds:
  - PIX_W default constant.
  - Typedefs pix_t, pairsum_t (PIX_W+1) and blksum_t (PIX_W+2).
  - Function avg4(blksum_t), whose body is selected by DOWNSCALE_ROUND_EN.
- Sub-module image_line_ram: simple dual-port, 1-cycle registered read, depth Max_Width/2, width Pra_Width+1. Inference-friendly, no reset on the array.
- The top holds the counters, the sum datapath and the sync delay registers.

## Test plan
- 4x4 frame, all pixels 100, continuous en -> 4 output pixels, all 100. o_image_hs is high for 2 lines. Each o_image_en comes 1 cycle after the input odd-column en.
- Block values 1,1,2,2 (sum 6) -> output 2 with DOWNSCALE_ROUND_EN, 1 without. Block 255 x4 -> 255 in both builds.
- 5x3 frame -> 2 outputs from rows 0-1. Column 4 and row 2 produce nothing.
- Max_Width=8, 10-pixel lines -> 4 outputs per output line. Pixels 8-9 do not corrupt buffer address 0.
- vs pulse asserted after 3 pixels of an odd row, then a clean 4x4 frame of ramp data -> only the 4 correct averages of the new frame are output.
- rst asserted for 1 cycle mid-row with random en gaps -> all outputs are 0 the next cycle, and the following frame matches the reference model bit-exactly.
